// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry-in for the ALU add path.
// One-cycle latency; flags are derived from the new sum and registered with it.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             out_valid
);

  function automatic logic [WIDTH:0] add_full(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z,
                                              input logic             c);
    return {1'b0, x} + {1'b0, z} + {{WIDTH{1'b0}}, c};
  endfunction

  // Overflow when both operands share a sign and the result's sign differs.
  function automatic logic signed_ovf(input logic x_msb,
                                      input logic z_msb,
                                      input logic s_msb);
    return (x_msb == z_msb) && (s_msb != x_msb);
  endfunction

  logic [WIDTH:0]   w_full_p0;
  logic [WIDTH-1:0] w_sum_p0;
  logic             w_ovf_p0;

  logic [WIDTH-1:0] r_y_p1;
  logic             r_cout_p1;
  logic             r_ovf_p1;
  logic             r_zero_p1;
  logic             r_neg_p1;
  logic             r_vld_p1;

  // Stage p0: combinational add and flag generation.
  always_comb begin
    w_full_p0 = add_full(a, b, cin);
    w_sum_p0  = w_full_p0[WIDTH-1:0];
    w_ovf_p0  = signed_ovf(a[WIDTH-1], b[WIDTH-1], w_sum_p0[WIDTH-1]);
  end

  // Stage p1: output register. Result fields hold when no new operand arrives,
  // but reset clears them so a dropped in-flight result leaves zeros behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_p1    <= '0;
      r_cout_p1 <= 1'b0;
      r_ovf_p1  <= 1'b0;
      r_zero_p1 <= 1'b0;
      r_neg_p1  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_y_p1    <= w_sum_p0;
        r_cout_p1 <= w_full_p0[WIDTH];
        r_ovf_p1  <= w_ovf_p0;
        r_zero_p1 <= (w_sum_p0 == '0);
        r_neg_p1  <= w_sum_p0[WIDTH-1];
      end
    end
  end

  assign y         = r_y_p1;
  assign cout      = r_cout_p1;
  assign ovf       = r_ovf_p1;
  assign zero      = r_zero_p1;
  assign neg       = r_neg_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the registered adder: directed vectors plus a
// randomized run with an independent integer reference model.
module tb_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] y;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .y        (y),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg),
    .out_valid(out_valid)
  );

  // Observation layout: {y, cout, ovf, zero, neg, out_valid}
  task automatic test_reset();
    logic [W+4:0] exp;
    rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
    exp = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i,
                 {y, cout, ovf, zero, neg, out_valid}, exp);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_flags();
    logic [W+4:0] exp;
    a = 8'hAA; b = 8'h8A; cin = 1'b1; in_valid = 1'b1;
    exp = {8'h35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    checks++;
    if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
      errors++;
      $display("FAIL add_cin1: got %h expected %h", {y, cout, ovf, zero, neg, out_valid}, exp);
    end
  endtask

  task automatic test_hold();
    logic [W+4:0] exp;
    a = 8'hAA; b = 8'h8A; cin = 1'b0; in_valid = 1'b1;
    exp = {8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    checks++;
    if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
      errors++;
      $display("FAIL add_cin0: got %h expected %h", {y, cout, ovf, zero, neg, out_valid}, exp);
    end
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    exp = {8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
        errors++;
        $display("FAIL hold[%0d]: got %h expected %h", i,
                 {y, cout, ovf, zero, neg, out_valid}, exp);
      end
    end
  endtask

  task automatic test_wrap_ovf();
    logic [W+4:0] exp;
    a = 8'hFF; b = 8'h00; cin = 1'b1; in_valid = 1'b1;
    exp = {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(posedge clk); #1;
    checks++;
    if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected %h", {y, cout, ovf, zero, neg, out_valid}, exp);
    end
    a = 8'h7F; b = 8'h01; cin = 1'b0;
    exp = {8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(posedge clk); #1;
    checks++;
    if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
      errors++;
      $display("FAIL pos_ovf: got %h expected %h", {y, cout, ovf, zero, neg, out_valid}, exp);
    end
    a = 8'h80; b = 8'h80; cin = 1'b0;
    exp = {8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(posedge clk); #1;
    checks++;
    if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
      errors++;
      $display("FAIL neg_ovf: got %h expected %h", {y, cout, ovf, zero, neg, out_valid}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{8'h01, 8'h10, 8'hFE};
    logic [W-1:0] vb [3] = '{8'h02, 8'h20, 8'h01};
    logic         vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [W+4:0] ve [3] = '{{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
                             {8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
                             {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i];
      @(posedge clk); #1;
      checks++;
      if ({y, cout, ovf, zero, neg, out_valid} !== ve[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h expected %h", i,
                 {y, cout, ovf, zero, neg, out_valid}, ve[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int           rst_at;
    int           s_u;
    int           s_s;
    logic [W-1:0] m_y  = y;
    logic         m_c  = cout;
    logic         m_o  = ovf;
    logic         m_z  = zero;
    logic         m_n  = neg;
    logic         m_v;
    logic [W+4:0] exp;
    rst_at = $urandom_range(100, 900);
    for (int i = 0; i < 1000; i++) begin
      rst_n    = (i != rst_at);
      in_valid = ($urandom_range(0, 7) != 0);
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      @(posedge clk); #1;
      if (!rst_n) begin
        m_y = '0; m_c = 1'b0; m_o = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
      end else if (in_valid) begin
        s_u = int'(a) + int'(b) + int'(cin);
        s_s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        m_y = W'(s_u);
        m_c = (s_u >= (1 << W));
        m_o = (s_s > (1 << (W - 1)) - 1) || (s_s < -(1 << (W - 1)));
        m_z = (s_u % (1 << W)) == 0;
        m_n = (s_u % (1 << W)) >= (1 << (W - 1));
        m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      exp = {m_y, m_c, m_o, m_z, m_n, m_v};
      checks++;
      if ({y, cout, ovf, zero, neg, out_valid} !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b rst_n=%b: got %h expected %h",
                 i, a, b, cin, rst_n, {y, cout, ovf, zero, neg, out_valid}, exp);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_flags();
    test_hold();
    test_wrap_ovf();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
